// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto a single-port word memory.
// One transaction in flight: IDLE -> ACCESS -> RESP, with back-to-back acceptance in RESP.
module mem_arbiter #(
  parameter int unsigned MEMSIZE  = 4096,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_valid_i,
  output logic        i_req_ready_o,
  input  logic [31:0] i_req_addr_i,
  output logic        i_rsp_valid_o,
  output logic [31:0] i_rsp_rdata_o,
  output logic        i_rsp_err_o,
  input  logic        d_req_valid_i,
  output logic        d_req_ready_o,
  input  logic        d_req_we_i,
  input  logic [31:0] d_req_addr_i,
  input  logic [31:0] d_req_wdata_i,
  output logic        d_rsp_valid_o,
  output logic [31:0] d_rsp_rdata_o,
  output logic        d_rsp_err_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic        port_q, port_d;     // 1 = load/store port
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        can_accept;
  logic        grant_i, grant_d;
  logic [31:0] acc_addr;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    port_d        = port_q;
    we_d          = we_q;
    err_d         = err_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    mem_wen_o     = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    i_rsp_valid_o = 1'b0;
    i_rsp_rdata_o = '0;
    i_rsp_err_o   = 1'b0;
    d_rsp_valid_o = 1'b0;
    d_rsp_rdata_o = '0;
    d_rsp_err_o   = 1'b0;

    can_accept = !rst_i && (state_q == IDLE || state_q == RESP);
    if (can_accept) begin
      if (i_req_valid_i && d_req_valid_i) begin
        if (wait_q == WW'(MAX_WAIT)) grant_i = 1'b1;
        else                         grant_d = 1'b1;
      end else if (i_req_valid_i) begin
        grant_i = 1'b1;
      end else if (d_req_valid_i) begin
        grant_d = 1'b1;
      end
    end
    acc_addr = grant_d ? d_req_addr_i : i_req_addr_i;

    unique case (state_q)
      IDLE: begin
        if (grant_i || grant_d) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = RESP;
        // Reset during ACCESS must suppress the write strobe combinationally.
        if (!rst_i) begin
          mem_addr_o  = addr_q;
          mem_wen_o   = we_q & ~err_q;
          mem_wdata_o = wdata_q;
        end
        rdata_d = (!we_q && !err_q) ? mem_rdata_i : '0;
      end
      RESP: begin
        if (!rst_i) begin
          if (port_q) begin
            d_rsp_valid_o = 1'b1;
            d_rsp_rdata_o = rdata_q;
            d_rsp_err_o   = err_q;
          end else begin
            i_rsp_valid_o = 1'b1;
            i_rsp_rdata_o = rdata_q;
            i_rsp_err_o   = err_q;
          end
        end
        state_d = (grant_i || grant_d) ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_i || grant_d) begin
      port_d  = grant_d;
      addr_d  = acc_addr;
      we_d    = grant_d & d_req_we_i;
      wdata_d = grant_d ? d_req_wdata_i : '0;
      err_d   = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(MEMSIZE));
    end

    if (grant_i) begin
      wait_d = '0;
    end else if (grant_d && i_req_valid_i && wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end

    i_req_ready_o = grant_i;
    d_req_ready_o = grant_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference word memory predicts every response
// at acceptance; a negedge monitor checks bus behaviour, latency and response data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_req_valid_i, i_req_ready_o;
  logic [31:0] i_req_addr_i;
  logic        i_rsp_valid_o, i_rsp_err_o;
  logic [31:0] i_rsp_rdata_o;
  logic        d_req_valid_i, d_req_ready_o, d_req_we_i;
  logic [31:0] d_req_addr_i, d_req_wdata_i;
  logic        d_rsp_valid_o, d_rsp_err_o;
  logic [31:0] d_rsp_rdata_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.MEMSIZE(4096), .MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_valid_i(i_req_valid_i), .i_req_ready_o(i_req_ready_o), .i_req_addr_i(i_req_addr_i),
    .i_rsp_valid_o(i_rsp_valid_o), .i_rsp_rdata_o(i_rsp_rdata_o), .i_rsp_err_o(i_rsp_err_o),
    .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o), .d_req_we_i(d_req_we_i),
    .d_req_addr_i(d_req_addr_i), .d_req_wdata_i(d_req_wdata_i),
    .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_rdata_o(d_rsp_rdata_o), .d_rsp_err_o(d_rsp_err_o),
    .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          acc_log[$];
  logic        grant_log[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];

  logic        acc_prev = 1'b0;
  logic        acc_we, acc_err;
  logic [31:0] acc_addr, acc_wdata;

  assign mem_rdata_i = dmem[mem_addr_o[11:2]];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_wen_o) dmem[mem_addr_o[11:2]] = mem_wdata_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: bus checks, response scoreboard, then prediction for a new acceptance.
  always @(negedge clk) begin
    exp_t e;
    logic port;
    logic [31:0] a;
    if (rst_i) begin
      check_eq("rst_i_ready", i_req_ready_o, 0);
      check_eq("rst_d_ready", d_req_ready_o, 0);
      check_eq("rst_rsp_valid", {i_rsp_valid_o, d_rsp_valid_o}, 0);
      check_eq("rst_rsp_data", i_rsp_rdata_o | d_rsp_rdata_o, 0);
      check_eq("rst_rsp_err", {i_rsp_err_o, d_rsp_err_o}, 0);
      check_eq("rst_mem", {31'b0, mem_wen_o} | mem_addr_o | mem_wdata_o, 0);
      sb.delete();
      acc_prev = 1'b0;
    end else begin
      if (acc_prev) begin
        check_eq("acc_mem_addr", mem_addr_o, acc_addr);
        check_eq("acc_mem_wen", mem_wen_o, acc_we && !acc_err);
        check_eq("acc_mem_wdata", mem_wdata_o, acc_wdata);
      end else begin
        check_eq("idle_mem_wen", mem_wen_o, 0);
        check_eq("idle_mem_addr", mem_addr_o, 0);
        check_eq("idle_mem_wdata", mem_wdata_o, 0);
      end
      if (i_rsp_valid_o || d_rsp_valid_o) begin
        check_eq("rsp_onehot", i_rsp_valid_o && d_rsp_valid_o, 0);
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_port", d_rsp_valid_o, e.port);
          check_eq("rsp_rdata", e.port ? d_rsp_rdata_o : i_rsp_rdata_o, e.data);
          check_eq("rsp_err", e.port ? d_rsp_err_o : i_rsp_err_o, e.err);
          check_eq("rsp_latency", cyc - e.cyc, 2);
        end
      end
      if (!i_rsp_valid_o) check_eq("i_rsp_idle", i_rsp_rdata_o | {31'b0, i_rsp_err_o}, 0);
      if (!d_rsp_valid_o) check_eq("d_rsp_idle", d_rsp_rdata_o | {31'b0, d_rsp_err_o}, 0);
      if (sb.size() > 0 && cyc > sb[0].cyc + 2) begin
        check_eq("rsp_missing", 0, 1);
        void'(sb.pop_front());
      end
      check_eq("ready_excl", i_req_ready_o && d_req_ready_o, 0);
      check_eq("ready_wo_valid", (i_req_ready_o && !i_req_valid_i) || (d_req_ready_o && !d_req_valid_i), 0);

      acc_prev = 1'b0;
      if (i_req_ready_o || d_req_ready_o) begin
        port      = d_req_ready_o;
        a         = port ? d_req_addr_i : i_req_addr_i;
        acc_addr  = a;
        acc_we    = port && d_req_we_i;
        acc_wdata = port ? d_req_wdata_i : 32'h0;
        acc_err   = (a[1:0] != 2'b00) || (a >= 32'd4096);
        acc_prev  = 1'b1;
        e.port = port;
        e.err  = acc_err;
        e.cyc  = cyc;
        e.data = 32'h0;
        if (!acc_err) begin
          if (acc_we) ref_mem[a[11:2]] = acc_wdata;
          else        e.data = ref_mem[a[11:2]];
        end
        sb.push_back(e);
        acc_log.push_back(cyc);
        grant_log.push_back(port);
      end
    end
  end

  // Drivers: start at posedge+#1, hold until accepted, release at the next posedge+#1.
  task automatic d_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    logic done = 1'b0;
    d_req_valid_i = 1'b1; d_req_we_i = we; d_req_addr_i = addr; d_req_wdata_i = wdata;
    while (!done && n < 100) begin
      @(negedge clk);
      if (d_req_ready_o) done = 1'b1;
      n++;
    end
    if (!done) check_eq("d_timeout", 0, 1);
    @(posedge clk); #1;
    d_req_valid_i = 1'b0;
  endtask

  task automatic i_req(input logic [31:0] addr);
    int n = 0;
    logic done = 1'b0;
    i_req_valid_i = 1'b1; i_req_addr_i = addr;
    while (!done && n < 100) begin
      @(negedge clk);
      if (i_req_ready_o) done = 1'b1;
      n++;
    end
    if (!done) check_eq("i_timeout", 0, 1);
    @(posedge clk); #1;
    i_req_valid_i = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int rel_cyc;
    logic [31:0] saved;
    for (int k = 0; k < 1024; k++) begin
      dmem[k]    = (k * 32'h01010101) ^ 32'hC0DE0000;
      ref_mem[k] = (k * 32'h01010101) ^ 32'hC0DE0000;
    end
    rst_i = 1'b1;
    i_req_valid_i = 1'b0; i_req_addr_i = '0;
    d_req_valid_i = 1'b0; d_req_we_i = 1'b0; d_req_addr_i = '0; d_req_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    rel_cyc = cyc;

    // Write then read back on the load/store port; first accept right after reset.
    acc_log.delete();
    d_req(1'b1, 32'h10, 32'hDEADBEEF);
    d_req(1'b0, 32'h10, 32'h0);
    drain();
    check_eq("first_accept_cyc", acc_log[0], rel_cyc);
    check_eq("ref_0x10", ref_mem[4], 32'hDEADBEEF);

    // Sustained contention: D,D,D,D,I,D,D,D,D,I.
    grant_log.delete();
    fork
      begin for (int k = 0; k < 8; k++) d_req(1'b0, k * 4, 32'h0); end
      begin for (int k = 0; k < 2; k++) i_req(32'h100 + k * 4); end
    join
    drain();
    check_eq("contend_count", grant_log.size(), 10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      check_eq($sformatf("contend_grant%0d", k), grant_log[k], (k % 5) != 4);

    // Instruction port alone; starvation counter must stay clear afterwards.
    grant_log.delete();
    for (int k = 0; k < 4; k++) i_req(32'h200 + k * 4);
    drain();
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check_eq($sformatf("ionly_grant%0d", k), grant_log[k], 0);
    grant_log.delete();
    fork
      begin for (int k = 0; k < 4; k++) d_req(1'b0, 32'h300 + k * 4, 32'h0); end
      begin i_req(32'h400); end
    join
    drain();
    check_eq("post_ionly_count", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check_eq($sformatf("post_ionly_grant%0d", k), grant_log[k], k != 4);

    // Error requests: misaligned write and out-of-range fetch.
    d_req(1'b1, 32'h1002, 32'h5555AAAA);
    i_req(32'h1000);
    drain();

    // Back-to-back reads, accepts two cycles apart.
    acc_log.delete();
    for (int k = 0; k < 4; k++) d_req(1'b0, k * 4, 32'h0);
    drain();
    check_eq("b2b_count", acc_log.size(), 4);
    for (int k = 1; k < 4 && k < acc_log.size(); k++)
      check_eq($sformatf("b2b_gap%0d", k), acc_log[k] - acc_log[k-1], 2);

    // Reset during the ACCESS cycle of a write aborts it.
    saved = ref_mem[8];
    d_req_valid_i = 1'b1; d_req_we_i = 1'b1; d_req_addr_i = 32'h20; d_req_wdata_i = 32'h12345678;
    @(negedge clk);
    check_eq("rst_mid_accept", d_req_ready_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    d_req_valid_i = 1'b0;
    ref_mem[8] = saved;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    d_req(1'b0, 32'h20, 32'h0);
    drain();
    check_eq("mem_0x20_kept", dmem[8], saved);

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
